// File: rtl/lif_pkg.sv
// Shared types, parameter defaults and saturation helper for the LIF layer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package lif_pkg;

    localparam int LIF_N_NEURONS  = 8;
    localparam int LIF_N_INPUTS   = 4;
    localparam int LIF_MEM_W      = 8;
    localparam int LIF_W_W        = 4;
    localparam int LIF_LEAK_SHIFT = 2;
    localparam int LIF_REFRAC     = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_UPDATE = 2'd1,
        ST_OUT    = 2'd2
    } lif_state_e;

    // Clamp a wide signed intermediate into the signed range of a mem_w-bit membrane.
    function automatic logic signed [31:0] lif_sat(input logic signed [31:0] v,
                                                   input int unsigned       mem_w);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (mem_w - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (mem_w - 1));
        if (v > hi) begin
            lif_sat = hi;
        end else if (v < lo) begin
            lif_sat = lo;
        end else begin
            lif_sat = v;
        end
    endfunction

endpackage

// File: rtl/lif_weight_mem.sv
// Weight register file: one write port, one combinational row read (all inputs of one neuron).
// Latency: write commits on the clock edge; row read is combinational from the registers.
// Backpressure: none; writes are accepted whenever we is high.
// Ports: we/waddr/wdata write one weight at index neuron*N_INPUTS+input;
//        raddr selects a neuron, row_dat returns its N_INPUTS weights packed, input 0 in the LSBs.
module lif_weight_mem
    import lif_pkg::*;
#(
    parameter int N_NEURONS = LIF_N_NEURONS,
    parameter int N_INPUTS  = LIF_N_INPUTS,
    parameter int W_W       = LIF_W_W,
    parameter int AW        = $clog2(N_NEURONS * N_INPUTS),
    parameter int IDX_W     = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      we,
    input  logic [AW-1:0]             waddr,
    input  logic [W_W-1:0]            wdata,
    input  logic [IDX_W-1:0]          raddr,
    output logic [N_INPUTS*W_W-1:0]   row_dat
);

    localparam int DEPTH = N_NEURONS * N_INPUTS;

    logic [W_W-1:0] wgt_q [DEPTH];
    logic [W_W-1:0] wgt_d [DEPTH];

    always_comb begin
        wgt_d = wgt_q;
        // Addresses past the last weight (non power-of-two depth) are dropped.
        if (we && (int'(waddr) < DEPTH)) begin
            wgt_d[waddr] = wdata;
        end
    end

    always_comb begin
        row_dat = '0;
        for (int i = 0; i < N_INPUTS; i++) begin
            row_dat[i*W_W +: W_W] = wgt_q[AW'(int'(raddr) * N_INPUTS + i)];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                wgt_q[k] <= '0;
            end
        end else begin
            wgt_q <= wgt_d;
        end
    end

endmodule

// File: rtl/lif_layer_seq.sv
// Sequential layer of leaky integrate-and-fire neurons, one neuron updated per cycle.
// Latency: input accept to out_valid = N_NEURONS+1 cycles (while ena stays high).
// Backpressure: in_ready only in IDLE; out_valid/out_spikes held in OUT until out_ready.
// Ports: ena freezes all state; cfg_we/cfg_addr/cfg_wdata load weights (IDLE only);
//        in_valid/in_ready/in_spikes/thr start a timestep; out_valid/out_ready/out_spikes
//        return it; busy is high outside IDLE.
// Build option: define LIF_REFRACTORY_EN to add per-neuron refractory counters (REFRAC steps).
module lif_layer_seq
    import lif_pkg::*;
#(
    parameter int N_NEURONS  = LIF_N_NEURONS,
    parameter int N_INPUTS   = LIF_N_INPUTS,
    parameter int MEM_W      = LIF_MEM_W,
    parameter int W_W        = LIF_W_W,
    parameter int LEAK_SHIFT = LIF_LEAK_SHIFT,
    parameter int REFRAC     = LIF_REFRAC
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    ena,
    input  logic                                    cfg_we,
    input  logic [$clog2(N_NEURONS*N_INPUTS)-1:0]   cfg_addr,
    input  logic signed [W_W-1:0]                   cfg_wdata,
    input  logic signed [MEM_W-1:0]                 thr,
    input  logic                                    in_valid,
    output logic                                    in_ready,
    input  logic [N_INPUTS-1:0]                     in_spikes,
    output logic                                    out_valid,
    input  logic                                    out_ready,
    output logic [N_NEURONS-1:0]                    out_spikes,
    output logic                                    busy
);

    localparam int AW    = $clog2(N_NEURONS * N_INPUTS);
    localparam int IDX_W = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;
    // Wide enough that m - leak + (sum of N_INPUTS weights) can never overflow before clamping.
    localparam int SUM_W = MEM_W + $clog2(N_INPUTS) + W_W;

    lif_state_e                 state_q, state_d;
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic [N_INPUTS-1:0]        spk_in_q, spk_in_d;
    logic signed [MEM_W-1:0]    thr_q, thr_d;
    logic [N_NEURONS-1:0]       out_spikes_q, out_spikes_d;
    logic signed [MEM_W-1:0]    memb_q [N_NEURONS];
    logic signed [MEM_W-1:0]    memb_d [N_NEURONS];

`ifdef LIF_REFRACTORY_EN
    localparam int REF_W = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;
    logic [REF_W-1:0]           ref_q [N_NEURONS];
    logic [REF_W-1:0]           ref_d [N_NEURONS];
`else
    // REFRAC has no effect without refractory counters.
    if (REFRAC < 0) begin : g_refrac_unused
    end
`endif

    logic                       wmem_we;
    logic [N_INPUTS*W_W-1:0]    row_dat;
    logic signed [SUM_W-1:0]    w_sum;
    logic signed [SUM_W-1:0]    m_ext;
    logic signed [SUM_W-1:0]    m_calc;
    logic signed [MEM_W-1:0]    m_sat;
    logic                       fire;

    lif_weight_mem #(
        .N_NEURONS (N_NEURONS),
        .N_INPUTS  (N_INPUTS),
        .W_W       (W_W),
        .AW        (AW),
        .IDX_W     (IDX_W)
    ) u_wmem (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (wmem_we),
        .waddr   (cfg_addr),
        .wdata   (cfg_wdata),
        .raddr   (idx_q),
        .row_dat (row_dat)
    );

    // Membrane datapath for the neuron at idx_q.
    always_comb begin
        logic signed [W_W-1:0] w_i;
        w_sum = '0;
        w_i   = '0;
        for (int i = 0; i < N_INPUTS; i++) begin
            w_i = row_dat[i*W_W +: W_W];
            if (spk_in_q[i]) begin
                w_sum = w_sum + SUM_W'(w_i);
            end
        end
        m_ext  = SUM_W'(memb_q[idx_q]);
        m_calc = m_ext - (m_ext >>> LEAK_SHIFT) + w_sum;
        m_sat  = MEM_W'(lif_sat(32'(m_calc), MEM_W));
        fire   = (m_sat >= thr_q);
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        spk_in_d     = spk_in_q;
        thr_d        = thr_q;
        out_spikes_d = out_spikes_q;
        memb_d       = memb_q;
`ifdef LIF_REFRACTORY_EN
        ref_d        = ref_q;
`endif
        wmem_we      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // A write in the accept cycle lands before neuron 0 reads its row.
                wmem_we = ena & cfg_we;
                if (ena && in_valid) begin
                    spk_in_d     = in_spikes;
                    thr_d        = thr;
                    idx_d        = '0;
                    out_spikes_d = '0;
                    state_d      = ST_UPDATE;
                end
            end
            ST_UPDATE: begin
                if (ena) begin
`ifdef LIF_REFRACTORY_EN
                    if (ref_q[idx_q] != '0) begin
                        memb_d[idx_q]       = '0;
                        out_spikes_d[idx_q] = 1'b0;
                        ref_d[idx_q]        = ref_q[idx_q] - REF_W'(1);
                    end else if (fire) begin
                        memb_d[idx_q]       = '0;
                        out_spikes_d[idx_q] = 1'b1;
                        ref_d[idx_q]        = REF_W'(REFRAC);
                    end else begin
                        memb_d[idx_q]       = m_sat;
                        out_spikes_d[idx_q] = 1'b0;
                    end
`else
                    if (fire) begin
                        memb_d[idx_q]       = '0;
                        out_spikes_d[idx_q] = 1'b1;
                    end else begin
                        memb_d[idx_q]       = m_sat;
                        out_spikes_d[idx_q] = 1'b0;
                    end
`endif
                    if (idx_q == IDX_W'(N_NEURONS - 1)) begin
                        idx_d   = '0;
                        state_d = ST_OUT;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            ST_OUT: begin
                if (ena && out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            spk_in_q     <= '0;
            thr_q        <= '0;
            out_spikes_q <= '0;
            for (int n = 0; n < N_NEURONS; n++) begin
                memb_q[n] <= '0;
`ifdef LIF_REFRACTORY_EN
                ref_q[n]  <= '0;
`endif
            end
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            spk_in_q     <= spk_in_d;
            thr_q        <= thr_d;
            out_spikes_q <= out_spikes_d;
            memb_q       <= memb_d;
`ifdef LIF_REFRACTORY_EN
            ref_q        <= ref_d;
`endif
        end
    end

    assign in_ready   = (state_q == ST_IDLE);
    assign out_valid  = (state_q == ST_OUT);
    assign busy       = (state_q != ST_IDLE);
    assign out_spikes = out_spikes_q;

endmodule

// File: tb/tb_lif_layer_seq.sv
// Randomized + directed bench for lif_layer_seq against a behavioural integer model.
// Two instances share all stimulus: default leak, and a weak leak that drives saturation.
// Summary: TB_RESULT checks=<n> failures=<n>
module tb_lif_layer_seq;

    localparam int NN     = 8;
    localparam int NI     = 4;
    localparam int MW     = 8;
    localparam int WW     = 4;
    localparam int AW     = 5;
    localparam int LS_A   = 2;
    localparam int LS_B   = 5;
    localparam int REFRAC = 2;
`ifdef LIF_REFRACTORY_EN
    localparam bit REF_ON = 1'b1;
`else
    localparam bit REF_ON = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 ena;
    logic                 cfg_we;
    logic [AW-1:0]        cfg_addr;
    logic signed [WW-1:0] cfg_wdata;
    logic signed [MW-1:0] thr;
    logic                 in_valid;
    logic [NI-1:0]        in_spikes;
    logic                 out_ready;
    logic                 in_ready_a, out_valid_a, busy_a;
    logic                 in_ready_b, out_valid_b, busy_b;
    logic [NN-1:0]        out_spikes_a, out_spikes_b;

    always #5 clk = ~clk;

    lif_layer_seq #(.LEAK_SHIFT(LS_A)) dut_a (
        .clk(clk), .rst_n(rst_n), .ena(ena), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_wdata(cfg_wdata), .thr(thr), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_spikes(in_spikes), .out_valid(out_valid_a), .out_ready(out_ready),
        .out_spikes(out_spikes_a), .busy(busy_a)
    );

    lif_layer_seq #(.LEAK_SHIFT(LS_B)) dut_b (
        .clk(clk), .rst_n(rst_n), .ena(ena), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_wdata(cfg_wdata), .thr(thr), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_spikes(in_spikes), .out_valid(out_valid_b), .out_ready(out_ready),
        .out_spikes(out_spikes_b), .busy(busy_b)
    );

    // ---------------- behavioural model ----------------
    int            w_m [NN*NI];
    int            mem_a [NN];
    int            mem_b [NN];
    int            ref_a [NN];
    int            ref_b [NN];
    logic [NN-1:0] exp_a, exp_b;
    bit            exp_busy, exp_ov;
    logic [NN-1:0] last_a;
    bit            co_we;
    int            co_addr, co_data;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic int clamp(input int v);
        int lo, hi;
        lo = -(1 << (MW - 1));
        hi = (1 << (MW - 1)) - 1;
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    function automatic void lif_one(input int m_in, input int r_in, input int sum,
                                    input int ls, input int th,
                                    output int m_out, output int r_out, output bit fired);
        int v;
        if (REF_ON && r_in > 0) begin
            m_out = 0; r_out = r_in - 1; fired = 1'b0;
        end else begin
            v = clamp(m_in - (m_in >>> ls) + sum);
            if (v >= th) begin
                m_out = 0; r_out = REF_ON ? REFRAC : 0; fired = 1'b1;
            end else begin
                m_out = v; r_out = r_in; fired = 1'b0;
            end
        end
    endfunction

    task automatic model_step(input logic [NI-1:0] sp, input int th);
        for (int n = 0; n < NN; n++) begin
            int sum;
            bit fa, fb;
            sum = 0;
            for (int i = 0; i < NI; i++) if (sp[i]) sum += w_m[n*NI+i];
            lif_one(mem_a[n], ref_a[n], sum, LS_A, th, mem_a[n], ref_a[n], fa);
            lif_one(mem_b[n], ref_b[n], sum, LS_B, th, mem_b[n], ref_b[n], fb);
            exp_a[n] = fa;
            exp_b[n] = fb;
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NN*NI; k++) w_m[k] = 0;
        for (int n = 0; n < NN; n++) begin
            mem_a[n] = 0; mem_b[n] = 0; ref_a[n] = 0; ref_b[n] = 0;
        end
        exp_a = '0; exp_b = '0; exp_busy = 1'b0; exp_ov = 1'b0;
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            chk("in_ready_a", 32'(in_ready_a), 32'(!exp_busy));
            chk("in_ready_b", 32'(in_ready_b), 32'(!exp_busy));
            chk("busy_a", 32'(busy_a), 32'(exp_busy));
            chk("busy_b", 32'(busy_b), 32'(exp_busy));
            chk("out_valid_a", 32'(out_valid_a), 32'(exp_ov));
            chk("out_valid_b", 32'(out_valid_b), 32'(exp_ov));
            if (exp_ov) begin
                chk("out_spikes_a", 32'(out_spikes_a), 32'(exp_a));
                chk("out_spikes_b", 32'(out_spikes_b), 32'(exp_b));
            end
        end
    end

    // ---------------- stimulus tasks ----------------
    task automatic cfg_write(input int a, input int d);
        @(negedge clk);
        cfg_we = 1'b1; cfg_addr = AW'(a); cfg_wdata = WW'(d);
        @(posedge clk);
        w_m[a] = d;
        #1 cfg_we = 1'b0;
    endtask

    // One timestep: accept, UPDATE (optionally frozen by ena for gap cycles), OUT held hold cycles.
    task automatic run_step(input logic [NI-1:0] sp, input int th, input int hold,
                            input int gap, input bit junk, input bit iv_out);
        @(negedge clk);
        in_valid = 1'b1; in_spikes = sp; thr = MW'(th);
        if (co_we) begin
            cfg_we = 1'b1; cfg_addr = AW'(co_addr); cfg_wdata = WW'(co_data);
        end
        @(posedge clk);
        if (co_we) w_m[co_addr] = co_data;
        model_step(sp, th);
        exp_busy = 1'b1;
        #1;
        in_valid = 1'b0; cfg_we = 1'b0; co_we = 1'b0;
        if (junk) begin
            cfg_we = 1'b1; cfg_addr = AW'($urandom); cfg_wdata = WW'($urandom);
        end
        if (gap > 0) begin
            ena = 1'b0;
            repeat (gap) @(posedge clk);
            #1 ena = 1'b1;
        end
        repeat (NN) @(posedge clk);
        #1;
        cfg_we = 1'b0;
        exp_ov = 1'b1;
        last_a = out_spikes_a;
        if (iv_out) begin
            in_valid = 1'b1; in_spikes = NI'($urandom);
        end
        repeat (hold) @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        exp_ov = 1'b0; exp_busy = 1'b0;
        #1 out_ready = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    bit pat20 [6];
    bit pat21 [3];

    initial begin
        rst_n = 1'b0; ena = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        thr = '0; in_valid = 1'b0; in_spikes = '0; out_ready = 1'b0; co_we = 1'b0;
        co_addr = 0; co_data = 0; last_a = '0;
        model_reset();
        if (REF_ON) pat20 = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        else        pat20 = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        pat21 = '{1'b0, 1'b0, 1'b1};

        repeat (2) @(posedge clk);
        #1;
        chk("reset_in_ready", 32'(in_ready_a), 32'd1);
        chk("reset_out_valid", 32'(out_valid_a), 32'd0);
        chk("reset_busy", 32'(busy_a), 32'd0);
        chk("reset_out_spikes", 32'(out_spikes_a), 32'd0);
        #1 rst_n = 1'b1;

        // Neuron 0 all +7, thr 20, all inputs: spikes on step 1 (and refractory pattern after).
        for (int i = 0; i < NI; i++) cfg_write(i, 7);
        for (int s = 0; s < 6; s++) begin
            run_step(4'b1111, 20, 0, 0, 1'b0, 1'b0);
            if (s == 0) chk("first_step_spikes", 32'(last_a), 32'h01);
            chk("neuron0_bit_seq", 32'(last_a[0]), 32'(pat20[s]));
        end

        // Reset while neuron 3 is being updated.
        @(negedge clk);
        in_valid = 1'b1; in_spikes = 4'b1111; thr = 8'sd20;
        @(posedge clk);
        exp_busy = 1'b1;
        #1 in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        #1;
        chk("midreset_in_ready", 32'(in_ready_a), 32'd1);
        chk("midreset_out_valid", 32'(out_valid_a), 32'd0);
        chk("midreset_busy", 32'(busy_a), 32'd0);
        run_step(4'b1111, 20, 0, 0, 1'b0, 1'b0);
        chk("after_reset_spikes", 32'(last_a), 32'h00);

        // Neuron 1, weight[0]=+6, thr 15: m = 6, 11, 15 -> 0,0,1.
        cfg_write(1*NI + 0, 6);
        for (int s = 0; s < 3; s++) begin
            run_step(4'b0001, 15, 0, 0, 1'b0, 1'b0);
            chk("neuron1_bit_seq", 32'(last_a[1]), 32'(pat21[s]));
        end

        // All weights -8 for 10 steps, then +7 with thr 127: no early spike, no wrap.
        for (int k = 0; k < NN*NI; k++) cfg_write(k, -8);
        for (int s = 0; s < 10; s++) run_step(4'b1111, 127, 0, 0, 1'b0, 1'b0);
        for (int k = 0; k < NN*NI; k++) cfg_write(k, 7);
        for (int s = 0; s < 8; s++) begin
            run_step(4'b1111, 127, 0, 0, 1'b0, 1'b0);
            if (s < 5) chk("no_early_spike", 32'(last_a), 32'h00);
        end

        // Output held 10 cycles with in_valid pushing; then ena freeze inside UPDATE.
        run_step(4'b1010, 20, 10, 0, 1'b0, 1'b1);
        run_step(4'b0110, 10, 1, 4, 1'b1, 1'b0);

        // Weight write coinciding with the accept is used by that timestep.
        co_we = 1'b1; co_addr = 2*NI + 1; co_data = -3;
        run_step(4'b0010, -5, 0, 0, 1'b0, 1'b0);

        // Random timesteps with random reconfiguration and ignored writes during UPDATE.
        for (int it = 0; it < 40; it++) begin
            int nw;
            nw = int'($urandom_range(3));
            for (int k = 0; k < nw; k++)
                cfg_write(int'($urandom_range(NN*NI - 1)), int'($urandom_range(15)) - 8);
            if ($urandom_range(3) == 0) begin
                co_we = 1'b1;
                co_addr = int'($urandom_range(NN*NI - 1));
                co_data = int'($urandom_range(15)) - 8;
            end
            run_step(NI'($urandom), int'($urandom_range(80)) - 20, int'($urandom_range(3)),
                     int'($urandom_range(2)), 1'($urandom_range(1)), 1'($urandom_range(1)));
        end

        repeat (2) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
